deser_word_align: RTL

- Parametrised per-lane word-alignment trainer for the sensor LVDS deserializer.
- Sits between the deserializer/gearbox output and the sync-word decoder. Covers CHANNEL_NUM data lanes plus one control lane.
- Watches each lane for the sensor training word and pulses a per-lane bitslip until the word is found for LOCK_CNT consecutive valid words.
- Reports per-lane lock, per-lane failure and a global alignment-done flag. It generalises the single bitslip-enable scheme to any lane count and word width, adding re-training and failure detection.

---
 rtl/deser_word_align.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/deser_word_align.sv
// Per-lane word-alignment trainer: hunts for the training word on every deserializer lane by
// issuing bitslip pulses, then reports lock, failure and global alignment.
module deser_word_align #(
    parameter int unsigned            CHANNEL_NUM      = 4,
    parameter int unsigned            DATA_WIDTH       = 10,
    parameter logic [DATA_WIDTH-1:0]  TRAINING_PATTERN = 10'h3A6,
    parameter int unsigned            LOCK_CNT         = 16,
    parameter int unsigned            BITSLIP_WAIT     = 4,
    parameter int unsigned            SLIP_CNT_WIDTH   = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       i_bitslip_en,
    input  logic                                       i_data_valid,
    input  logic [(CHANNEL_NUM+1)*DATA_WIDTH-1:0]      iv_data,
    output logic [CHANNEL_NUM:0]                       ov_bitslip,
    output logic [CHANNEL_NUM:0]                       ov_lane_locked,
    output logic [CHANNEL_NUM:0]                       ov_lane_fail,
    output logic [(CHANNEL_NUM+1)*SLIP_CNT_WIDTH-1:0]  ov_slip_cnt,
    output logic                                       o_align_done
);

    localparam int unsigned LANES = CHANNEL_NUM + 1;

    localparam logic [7:0]                LockLast = 8'(LOCK_CNT - 1);
    localparam logic [3:0]                WaitLast = 4'(BITSLIP_WAIT - 1);
    localparam logic [SLIP_CNT_WIDTH-1:0] SlipMax  = SLIP_CNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [2:0] {
        StCheck,
        StSlip,
        StWait,
        StLocked,
        StFail
    } state_e;

    state_e                    state_q     [LANES];
    logic [7:0]                match_cnt_q [LANES];
    logic [3:0]                wait_cnt_q  [LANES];
    logic [SLIP_CNT_WIDTH-1:0] slip_cnt_q  [LANES];

    logic [LANES-1:0] bitslip_q;
    logic [LANES-1:0] locked_q;
    logic [LANES-1:0] fail_q;
    logic             en_q;
    logic             align_done_q;
    logic             en_rise;
    logic [LANES-1:0] word_match;

    assign en_rise = i_bitslip_en & ~en_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign word_match[g] = (iv_data[g*DATA_WIDTH +: DATA_WIDTH] == TRAINING_PATTERN);
        assign ov_slip_cnt[g*SLIP_CNT_WIDTH +: SLIP_CNT_WIDTH] = slip_cnt_q[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= 1'b0;
            align_done_q <= 1'b0;
            bitslip_q    <= '0;
            locked_q     <= '0;
            fail_q       <= '0;
            for (int n = 0; n < LANES; n++) begin
                state_q[n]     <= StCheck;
                match_cnt_q[n] <= '0;
                wait_cnt_q[n]  <= '0;
                slip_cnt_q[n]  <= '0;
            end
        end else begin
            en_q         <= i_bitslip_en;
            align_done_q <= &locked_q;
            // Pulse is only ever high for the single cycle a lane spends in StSlip.
            bitslip_q    <= '0;
            for (int n = 0; n < LANES; n++) begin
                if (!i_bitslip_en) begin
                    // Frozen: hold every lane exactly where it is.
                end else if (en_rise) begin
                    fail_q[n] <= 1'b0;
                    if (state_q[n] != StLocked) begin
                        state_q[n]     <= StCheck;
                        match_cnt_q[n] <= '0;
                        wait_cnt_q[n]  <= '0;
                        slip_cnt_q[n]  <= '0;
                    end
                end else begin
                    unique case (state_q[n])
                        StCheck: begin
                            if (i_data_valid) begin
                                if (word_match[n]) begin
                                    match_cnt_q[n] <= match_cnt_q[n] + 8'd1;
                                    if (match_cnt_q[n] == LockLast) begin
                                        state_q[n]  <= StLocked;
                                        locked_q[n] <= 1'b1;
                                    end
                                end else begin
                                    match_cnt_q[n] <= '0;
                                    if (slip_cnt_q[n] < SlipMax) begin
                                        state_q[n]   <= StSlip;
                                        bitslip_q[n] <= 1'b1;
                                    end else begin
                                        state_q[n] <= StFail;
                                    end
                                end
                            end
                        end
                        StSlip: begin
                            slip_cnt_q[n] <= slip_cnt_q[n] + SLIP_CNT_WIDTH'(1);
                            wait_cnt_q[n] <= '0;
                            state_q[n]    <= StWait;
                        end
                        StWait: begin
                            // Words here are still in flight through the deserializer.
                            if (i_data_valid) begin
                                if (wait_cnt_q[n] == WaitLast) begin
                                    wait_cnt_q[n] <= '0;
                                    state_q[n]    <= StCheck;
                                end else begin
                                    wait_cnt_q[n] <= wait_cnt_q[n] + 4'd1;
                                end
                            end
                        end
                        StLocked: begin
                            if (i_data_valid && !word_match[n]) begin
                                state_q[n]     <= StCheck;
                                match_cnt_q[n] <= '0;
                                slip_cnt_q[n]  <= '0;
                                locked_q[n]    <= 1'b0;
                            end
                        end
                        StFail: begin
                            fail_q[n]     <= 1'b1;
                            slip_cnt_q[n] <= '0;
                            state_q[n]    <= StCheck;
                        end
                        default: begin
                            state_q[n] <= StCheck;
                        end
                    endcase
                end
            end
        end
    end

    assign ov_bitslip     = bitslip_q;
    assign ov_lane_locked = locked_q;
    assign ov_lane_fail   = fail_q;
    assign o_align_done   = align_done_q;

endmodule
